// File: rtl/nibbler_pkg.sv
// rtl/nibbler_pkg.sv - opcode, FSM state and ALU operation types for the nibbler core
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_JC   = 4'h0,
    OP_JNC  = 4'h1,
    OP_CMPI = 4'h2,
    OP_CMPM = 4'h3,
    OP_LIT  = 4'h4,
    OP_IN   = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JZ   = 4'h8,
    OP_JNZ  = 4'h9,
    OP_ADDI = 4'hA,
    OP_ADDM = 4'hB,
    OP_JMP  = 4'hC,
    OP_OUT  = 4'hD,
    OP_NORI = 4'hE,
    OP_NORM = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_CMP  = 2'd1,
    ALU_NOR  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_e;

endpackage

// File: rtl/nibbler_alu_p.sv
// rtl/nibbler_alu_p.sv - combinational ADD/CMP/NOR/pass datapath with carry and zero
module alu_p
  import nibbler_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = b;
    c   = 1'b0;
    z   = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD: begin
        y = sum[DATA_W-1:0];
        c = sum[DATA_W];
        z = (sum[DATA_W-1:0] == '0);
      end
      // Compare leaves A intact; carry means no borrow.
      ALU_CMP: begin
        y = a;
        c = (a >= b);
        z = (a == b);
      end
      ALU_NOR: begin
        y = ~(a | b);
        z = (~(a | b) == '0);
      end
      default: y = b;
    endcase
  end

endmodule

// File: rtl/nibbler_core_p.sv
// rtl/nibbler_core_p.sv - two-phase fetch/execute nibbler CPU core
// Optional fetch stalling on prog_ready is enabled by NIBBLER_STALL_EN.
module nibbler_core_p
  import nibbler_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   prog_addr,
  input  logic [ADDR_W+3:0]   prog_data,
`ifdef NIBBLER_STALL_EN
  input  logic                prog_ready,
`endif
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   in_data,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_strobe,
  output logic [DATA_W-1:0]   acc,
  output logic                c_flag,
  output logic                z_flag,
  output logic                phase
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W+3:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                strobe_q, strobe_d;

  opcode_e             opcode;
  logic [ADDR_W-1:0]   field;
  logic [DATA_W-1:0]   imm;
  logic                fetch_go;
  logic [1:0]          alu_op;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_c;
  logic                alu_z;

  assign opcode = opcode_e'(ir_q[ADDR_W+3:ADDR_W]);
  assign field  = ir_q[ADDR_W-1:0];
  assign imm    = ir_q[DATA_W-1:0];

`ifdef NIBBLER_STALL_EN
  assign fetch_go = prog_ready;
`else
  assign fetch_go = 1'b1;
`endif

  // Odd arithmetic opcodes take the RAM operand, even ones the immediate.
  always_comb begin
    alu_b  = ir_q[ADDR_W] ? ram_rdata : imm;
    alu_op = ALU_PASS;
    case (opcode)
      OP_CMPI, OP_CMPM: alu_op = ALU_CMP;
      OP_ADDI, OP_ADDM: alu_op = ALU_ADD;
      OP_NORI, OP_NORM: alu_op = ALU_NOR;
      default:          alu_op = ALU_PASS;
    endcase
  end

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .op (alu_op),
    .a  (a_q),
    .b  (alu_b),
    .y  (alu_y),
    .c  (alu_c),
    .z  (alu_z)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    c_d      = c_q;
    z_d      = z_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    if (state_q == ST_FETCH) begin
      if (fetch_go) begin
        ir_d    = prog_data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXEC;
      end
    end else begin
      state_d = ST_FETCH;
      case (opcode)
        OP_JC:   if (c_q)  pc_d = field;
        OP_JNC:  if (!c_q) pc_d = field;
        OP_JZ:   if (z_q)  pc_d = field;
        OP_JNZ:  if (!z_q) pc_d = field;
        OP_JMP:  pc_d = field;
        OP_CMPI, OP_CMPM: begin
          c_d = alu_c;
          z_d = alu_z;
        end
        OP_ADDI, OP_ADDM, OP_NORI, OP_NORM: begin
          a_d = alu_y;
          c_d = alu_c;
          z_d = alu_z;
        end
        OP_LIT:  a_d = imm;
        OP_IN:   a_d = in_data;
        OP_LD:   a_d = ram_rdata;
        OP_OUT: begin
          out_d    = a_q;
          strobe_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      out_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      c_q      <= c_d;
      z_q      <= z_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

  // Write enable is combinational so an async reset mid-EXEC kills the store.
  assign ram_we     = (state_q == ST_EXEC) && (opcode == OP_ST);
  assign ram_wdata  = a_q;
  assign ram_addr   = field;
  assign prog_addr  = pc_q;
  assign out_data   = out_q;
  assign out_strobe = strobe_q;
  assign acc        = a_q;
  assign c_flag     = c_q;
  assign z_flag     = z_q;
  assign phase      = (state_q == ST_EXEC);

endmodule

// File: tb/tb_nibbler_core_p.sv
// tb/tb_nibbler_core_p.sv - directed self-checking bench for nibbler_core_p
// Stall scenario is compiled in only when NIBBLER_STALL_EN is defined.
module tb_nibbler_core_p;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] prog_addr;
  logic [15:0] prog_data;
  logic        prog_ready;
  logic [11:0] ram_addr;
  logic [3:0]  ram_rdata;
  logic [3:0]  ram_wdata;
  logic        ram_we;
  logic [3:0]  in_data;
  logic [3:0]  out_data;
  logic        out_strobe;
  logic [3:0]  acc;
  logic        c_flag;
  logic        z_flag;
  logic        phase;

  logic [15:0] prog [0:4095];
  logic [3:0]  ram  [0:4095];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign prog_data = prog[prog_addr];
  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  nibbler_core_p #(.DATA_W(4), .ADDR_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
`ifdef NIBBLER_STALL_EN
    .prog_ready (prog_ready),
`endif
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .acc        (acc),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .phase      (phase)
  );

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      prog[i] = 16'h0000;
      ram[i]  = 4'h0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_mem();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (prog_addr !== 12'h000 || acc !== 4'h0 || c_flag !== 1'b0 || z_flag !== 1'b0 ||
        phase !== 1'b0 || out_data !== 4'h0 || out_strobe !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_state pc=%h a=%h c=%b z=%b ph=%b out=%h stb=%b we=%b need all zero",
               prog_addr, acc, c_flag, z_flag, phase, out_data, out_strobe, ram_we);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    clear_mem();
    prog[0] = 16'h4005;
    prog[1] = 16'hA00C;
    do_reset();
    step(4);
    checks++;
    if (acc !== 4'h1 || c_flag !== 1'b1 || z_flag !== 1'b0) begin
      failures++;
      $display("FAIL add_carry a=%h c=%b z=%b need a=1 c=1 z=0", acc, c_flag, z_flag);
    end
    checks++;
    if (prog_addr !== 12'h002 || phase !== 1'b0) begin
      failures++;
      $display("FAIL add_pc pc=%h ph=%b need pc=002 ph=0", prog_addr, phase);
    end
  endtask

  task automatic test_cmp_jump();
    clear_mem();
    prog[0]     = 16'h4007;
    prog[1]     = 16'h2007;
    prog[2]     = 16'h8040;
    prog[12'h040] = 16'h4003;
    do_reset();
    step(6);
    checks++;
    if (acc !== 4'h7 || c_flag !== 1'b1 || z_flag !== 1'b1 || prog_addr !== 12'h040) begin
      failures++;
      $display("FAIL cmp_equal a=%h c=%b z=%b pc=%h need a=7 c=1 z=1 pc=040",
               acc, c_flag, z_flag, prog_addr);
    end
    step(2);
    checks++;
    if (acc !== 4'h3 || c_flag !== 1'b1 || z_flag !== 1'b1) begin
      failures++;
      $display("FAIL lit_keeps_flags a=%h c=%b z=%b need a=3 c=1 z=1", acc, c_flag, z_flag);
    end
    prog[1] = 16'h2008;
    do_reset();
    step(6);
    checks++;
    if (acc !== 4'h7 || c_flag !== 1'b0 || z_flag !== 1'b0 || prog_addr !== 12'h003) begin
      failures++;
      $display("FAIL cmp_less a=%h c=%b z=%b pc=%h need a=7 c=0 z=0 pc=003",
               acc, c_flag, z_flag, prog_addr);
    end
  endtask

  task automatic test_mem_out();
    int we_cycles;
    int stb_cycles;
    logic [11:0] we_addr;
    logic [3:0]  we_data;
    clear_mem();
    prog[0] = 16'h400A;
    prog[1] = 16'h7123;
    prog[2] = 16'h4000;
    prog[3] = 16'h6123;
    prog[4] = 16'hD000;
    we_cycles  = 0;
    stb_cycles = 0;
    we_addr    = '0;
    we_data    = '0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (ram_we === 1'b1) begin
        we_cycles++;
        we_addr = ram_addr;
        we_data = ram_wdata;
      end
      if (out_strobe === 1'b1) stb_cycles++;
    end
    checks++;
    if (we_cycles != 1 || we_addr !== 12'h123 || we_data !== 4'hA) begin
      failures++;
      $display("FAIL store_pulse cycles=%0d addr=%h data=%h need 1 123 a",
               we_cycles, we_addr, we_data);
    end
    checks++;
    if (ram[12'h123] !== 4'hA || acc !== 4'hA) begin
      failures++;
      $display("FAIL load_back ram=%h a=%h need a a", ram[12'h123], acc);
    end
    checks++;
    if (out_data !== 4'hA || stb_cycles != 1) begin
      failures++;
      $display("FAIL out_port out=%h strobes=%0d need a 1", out_data, stb_cycles);
    end
  endtask

  task automatic test_in_port();
    clear_mem();
    prog[0] = 16'h5000;
    in_data = 4'h6;
    do_reset();
    step(2);
    checks++;
    if (acc !== 4'h6 || c_flag !== 1'b0 || z_flag !== 1'b0) begin
      failures++;
      $display("FAIL in_port a=%h c=%b z=%b need 6 0 0", acc, c_flag, z_flag);
    end
    in_data = 4'h0;
  endtask

  task automatic test_wrap_nor();
    clear_mem();
    prog[0]       = 16'h400F;
    prog[1]       = 16'hA001;
    prog[2]       = 16'hCFFF;
    prog[12'hFFF] = 16'hE000;
    do_reset();
    step(4);
    checks++;
    if (acc !== 4'h0 || c_flag !== 1'b1 || z_flag !== 1'b1) begin
      failures++;
      $display("FAIL add_to_zero a=%h c=%b z=%b need 0 1 1", acc, c_flag, z_flag);
    end
    step(2);
    checks++;
    if (prog_addr !== 12'hFFF) begin
      failures++;
      $display("FAIL jmp_top pc=%h need fff", prog_addr);
    end
    step(2);
    checks++;
    if (acc !== 4'hF || c_flag !== 1'b0 || z_flag !== 1'b0 || prog_addr !== 12'h000) begin
      failures++;
      $display("FAIL nor_wrap a=%h c=%b z=%b pc=%h need f 0 0 000",
               acc, c_flag, z_flag, prog_addr);
    end
  endtask

  task automatic test_reset_mid_store();
    clear_mem();
    prog[0] = 16'h4005;
    prog[1] = 16'h7200;
    do_reset();
    step(3);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 12'h200) begin
      failures++;
      $display("FAIL store_exec we=%b addr=%h need 1 200", ram_we, ram_addr);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0 || acc !== 4'h0 || prog_addr !== 12'h000 || phase !== 1'b0) begin
      failures++;
      $display("FAIL async_reset we=%b a=%h pc=%h ph=%b need 0 0 000 0",
               ram_we, acc, prog_addr, phase);
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ram[12'h200] !== 4'h0) begin
      failures++;
      $display("FAIL store_suppressed ram=%h need 0", ram[12'h200]);
    end
    step(1);
    checks++;
    if (phase !== 1'b1 || prog_addr !== 12'h001) begin
      failures++;
      $display("FAIL refetch_zero ph=%b pc=%h need 1 001", phase, prog_addr);
    end
  endtask

`ifdef NIBBLER_STALL_EN
  task automatic test_stall();
    clear_mem();
    prog[0] = 16'h4009;
    do_reset();
    prog_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (phase !== 1'b0 || prog_addr !== 12'h000 || ram_we !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d ph=%b pc=%h need 0 000", i, phase, prog_addr);
      end
    end
    prog_ready = 1'b1;
    step(2);
    checks++;
    if (acc !== 4'h9 || prog_addr !== 12'h001) begin
      failures++;
      $display("FAIL stall_release a=%h pc=%h need 9 001", acc, prog_addr);
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    prog_ready = 1'b1;
    in_data    = 4'h0;
    test_reset();
    test_add();
    test_cmp_jump();
    test_mem_out();
    test_in_port();
    test_wrap_nor();
    test_reset_mid_store();
`ifdef NIBBLER_STALL_EN
    test_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibbler_core_p.md
NIBBLER_CORE_P -- requirements
Module: nibbler_core_p

Interface
REQ-001 Parameter DATA_W, 4, accumulator/data-bus width (4..16).
REQ-002 Parameter ADDR_W, 12, program and data address width; SHALL be >= DATA_W.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 prog_addr  output  ADDR_W  program-memory address (= PC).
REQ-006 prog_data  input  4+ADDR_W  instruction word: opcode = top 4 bits, field F = low ADDR_W bits.
REQ-007 prog_ready  input  1  program word valid (present only with NIBBLER_STALL_EN).
REQ-008 ram_addr  output  ADDR_W  data-RAM address (= F of IR).
REQ-009 ram_rdata  input  DATA_W  combinational RAM read data.
REQ-010 ram_wdata / ram_we  output  DATA_W / 1  RAM write data (= A) and write enable.
REQ-011 in_data  input  DATA_W  input port; out_data  output  DATA_W  registered output port.
REQ-012 out_strobe  output  1  one-cycle pulse when out_data loads.
REQ-013 acc, c_flag, z_flag, phase  output  DATA_W,1,1,1  debug visibility of A, C, Z, FSM state.

Function
REQ-014 FSM SHALL have states FETCH (phase=0) and EXEC (phase=1); FETCH->EXEC->FETCH; one instruction per 2 cycles absent stalls.
REQ-015 FETCH edge: IR <= prog_data, PC <= PC+1 modulo 2^ADDR_W (PC = all-ones wraps to 0).
REQ-016 EXEC: immediate I = F[DATA_W-1:0]; memory operand M = ram_rdata at ram_addr = F; effects commit at EXEC edge.
REQ-017 Opcodes 0 JC,1 JNC,8 JZ,9 JNZ,C JMP: PC <= F when condition (C=1, C=0, Z=1, Z=0, always) true, else PC unchanged.
REQ-018 2 CMPI/3 CMPM: compute A-I / A-M; C <= 1 iff A >= operand (no borrow), Z <= 1 iff equal; A unchanged.
REQ-019 A ADDI/B ADDM: {C,A} <= A+operand (DATA_W+1 bits); Z <= (new A == 0).
REQ-020 E NORI/F NORM: A <= ~(A|operand); Z <= (new A == 0); C <= 0.
REQ-021 4 LIT: A <= I; 5 IN: A <= in_data; 6 LD: A <= M; flags unchanged.
REQ-022 7 ST: ram_we = 1 combinationally during EXEC only, ram_wdata = A; ram_we = 0 in all other cycles/opcodes.
REQ-023 D OUT: out_data <= A at EXEC edge; out_strobe = 1 for the following single cycle.
REQ-024 Flags SHALL change only on opcodes 2,3,A,B,E,F.

Reset
REQ-025 reset asserted SHALL immediately force PC=0, IR=0, A=0, C=0, Z=0, out_data=0, out_strobe=0, state FETCH, regardless of phase.
REQ-026 After deassertion first fetch SHALL be from address 0; reset mid-EXEC SHALL suppress that instruction's commit (no RAM write, no out strobe).

Configuration
REQ-027 Macro NIBBLER_STALL_EN: when defined, port prog_ready exists; in FETCH with prog_ready=0 the FSM SHALL stay in FETCH, PC and IR hold, ram_we=0.
REQ-028 Without NIBBLER_STALL_EN: port absent, every FETCH completes in one cycle.

Structure
REQ-029 Package nibbler_pkg SHALL hold the 4-bit opcode enum and the FETCH/EXEC state enum.
REQ-030 Sub-module alu_p (parameter DATA_W) SHALL implement ADD/CMP/NOR/pass with carry and zero outputs; core holds all registers.

Verification (DATA_W=4, ADDR_W=12)
REQ-031 Reset, program LIT 5; ADDI 0xC -> after 4 cycles A=1, C=1, Z=0.
REQ-032 LIT 7; CMPI 7; JZ 0x040 -> C=1, Z=1, A=7, PC=0x040 after JZ EXEC; with CMPI 8 instead, C=0, Z=0, PC falls through.
REQ-033 LIT 0xA; ST 0x123; LIT 0; LD 0x123; OUT -> ram_we high one cycle with addr 0x123 data 0xA; out_data=0xA, out_strobe single pulse.
REQ-034 JMP 0xFFF with NORI 0 at 0xFFF (A=0) -> A=0xF, Z=0, C=0; next fetch address wraps to 0x000.
REQ-035 NIBBLER_STALL_EN: hold prog_ready=0 for 3 cycles during a FETCH -> phase stays 0, PC holds, instruction executes once after ready rises.
REQ-036 Assert reset during EXEC of ST -> ram_we=0 immediately, all registers zero, first fetch after release at 0x000.
